// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: session states and the
// byte stride between consecutive 32-bit memory words.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

// File: rtl/prog_loader_fifo_2deep.sv
// Two-entry FIFO buffering data-memory read results for the dump stream.
// Head is forced to zero while empty so the dump port idles at zero.
module fifo_2deep #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_pop;

  assign valid  = (count != 2'd0);
  assign head   = valid ? mem[rd_ptr] : '0;
  assign do_pop = pop && valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a program into instruction memory, runs the cpu
// for a fixed cycle count, then streams a window of data memory back out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [31:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [31:0]      wdata_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             cpu_enable,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output state_t           dbg_state
);

  // Both streams: a word moves on a rising edge where valid && ready are
  // both high; the source holds data stable while valid && !ready.

  localparam int K_W = $clog2(IMEM_WORDS + 1);

  state_t           state;
  logic [K_W-1:0]   load_k;
  logic             load_fin;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] dump_len;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] xfer_cnt;
  logic             rd_pend;
  logic [1:0]       fifo_count;
  logic             m_fire;
  logic             issue;

  assign ren_ext     = 1'b0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;

  assign busy      = (state == LOAD) || (state == RUN) || (state == DUMP);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign m_fire = m_valid && m_ready;

  // Buffered words plus reads still in the sram pipeline never exceed two.
  assign issue = (state == DUMP) && (iss_cnt != dump_len) &&
                 ((3'(fifo_count) + 3'(rd_pend) + 3'(ren_ext_2)) < 3'd2);

  fifo_2deep #(.DATA_W(32)) u_fifo (
    .clk       (clk),
    .rst_n     (arst_n),
    .push      (rd_pend),
    .push_data (rdata_ext_2),
    .pop       (m_fire),
    .valid     (m_valid),
    .head      (m_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      wen_ext    <= 1'b0;
      addr_ext   <= '0;
      wdata_ext  <= '0;
      ren_ext_2  <= 1'b0;
      addr_ext_2 <= '0;
      cpu_enable <= 1'b0;
      overflow   <= 1'b0;
      load_k     <= '0;
      load_fin   <= 1'b0;
      run_len    <= '0;
      dump_len   <= '0;
      run_cnt    <= '0;
      iss_cnt    <= '0;
      xfer_cnt   <= '0;
      rd_pend    <= 1'b0;
    end else begin
      wen_ext    <= 1'b0;
      addr_ext   <= '0;
      wdata_ext  <= '0;
      ren_ext_2  <= 1'b0;
      addr_ext_2 <= '0;
      rd_pend    <= ren_ext_2;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            s_ready  <= 1'b1;
            overflow <= 1'b0;
            load_k   <= '0;
            load_fin <= 1'b0;
            run_len  <= run_cycles;
            dump_len <= dump_words;
            run_cnt  <= '0;
            iss_cnt  <= '0;
            xfer_cnt <= '0;
          end
        end

        LOAD: begin
          // load_fin marks the cycle carrying the final write; leave after it.
          if (load_fin) begin
            if (run_len != '0) begin
              state      <= RUN;
              cpu_enable <= 1'b1;
              run_cnt    <= CNT_W'(1);
            end else if (dump_len != '0) begin
              state <= DUMP;
            end else begin
              state <= DONE;
            end
          end else if (s_valid && s_ready) begin
            if (load_k < K_W'(IMEM_WORDS)) begin
              wen_ext   <= 1'b1;
              addr_ext  <= 32'(load_k) * ADDR_STRIDE;
              wdata_ext <= s_data;
              load_k    <= load_k + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
            if (s_last) begin
              load_fin <= 1'b1;
              s_ready  <= 1'b0;
            end
          end
        end

        RUN: begin
          if (run_cnt == run_len) begin
            cpu_enable <= 1'b0;
            state      <= (dump_len != '0) ? DUMP : DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end

        DUMP: begin
          if (issue) begin
            ren_ext_2  <= 1'b1;
            addr_ext_2 <= 32'(iss_cnt) * ADDR_STRIDE;
            iss_cnt    <= iss_cnt + 1'b1;
          end
          if (m_fire) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (xfer_cnt == dump_len - 1'b1) begin
              state <= DONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load/run/dump sessions plus hand-written
// reset and start-while-busy sequences, with scoreboards on both memories.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int IMEM_WORDS = 4;
  localparam int CNT_W      = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             arst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic [CNT_W-1:0] dump_words = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      s_data = '0;
  logic             s_last = 1'b0;
  logic [31:0]      addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, m_data;
  logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]      rdata_ext_2;
  logic             cpu_enable, m_valid, busy, done, overflow;
  logic             m_ready = 1'b0;
  state_t           dbg_state;

  prog_loader #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .run_cycles(run_cycles), .dump_words(dump_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .overflow(overflow), .dbg_state(dbg_state)
  );

  // Data memory with one-cycle read latency.
  logic [31:0] dmem [64];
  always @(posedge clk) if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[7:2]];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_m_q[$];
  logic [63:0] exp_w_q[$];
  int   en_cnt = 0;
  int   en_rises = 0;
  logic en_prev = 1'b0;
  int   m_xfer = 0;
  logic hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wen_ext) begin
      if (exp_w_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL imem_unexpected: got write %0h@%0h expected none", wdata_ext, addr_ext);
      end else begin
        check("imem_write", {addr_ext, wdata_ext}, exp_w_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!arst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("m_hold", {m_valid, m_data}, {1'b1, hold_data});
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        m_xfer++;
        if (exp_m_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dump_unexpected: got %0h expected none", m_data);
        end else begin
          check("dump_data", m_data, exp_m_q.pop_front());
        end
      end
    end
    if (cpu_enable) en_cnt++;
    if (cpu_enable && !en_prev) en_rises++;
    en_prev = cpu_enable;
  end

  initial forever begin
    @(posedge clk); #1;
    m_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  logic [31:0] fixed_w [3];

  task automatic check_reset_outputs();
    check("rst_ctrl", {s_ready, wen_ext, ren_ext_2, cpu_enable, m_valid, busy, done, overflow}, 0);
    check("rst_imem", {addr_ext, wdata_ext}, 0);
    check("rst_dmem", {addr_ext_2, m_data}, 0);
    check("rst_state", dbg_state, IDLE);
  endtask

  task automatic start_session(input int run, input int dump);
    @(posedge clk); #1;
    start = 1'b1; run_cycles = run; dump_words = dump;
    en_cnt = 0; en_rises = 0; m_xfer = 0;
    for (int i = 0; i < dump; i++) exp_m_q.push_back(dmem[i]);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_state", dbg_state, LOAD);
    check("start_flags", {s_ready, busy, done, overflow}, 4'b1100);
  endtask

  task automatic feed_words(input int n, input bit use_fixed);
    logic [31:0] w;
    int t;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (use_fixed && k < 3) w = fixed_w[k];
      else w = $urandom;
      s_valid = 1'b1; s_data = w; s_last = (k == n - 1);
      t = 0;
      while (!s_ready && t < 20) begin @(negedge clk); t++; end
      check("s_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      if (k < IMEM_WORDS) exp_w_q.push_back({32'(k * 4), w});
      @(negedge clk);
      check("wen_latency", wen_ext, (k < IMEM_WORDS));
    end
    check("load_drain", {dbg_state, s_ready}, {LOAD, 1'b0});
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    check("done", done, 1);
  endtask

  typedef struct {
    int     n_words;
    int     run;
    int     dump;
    bit     use_fixed;
    bit     start_in_run;
    bit     exp_ovf;
    int     exp_en;
    state_t exp_after;
  } vec_t;

  vec_t vecs [5];

  task automatic run_session(input vec_t v);
    start_session(v.run, v.dump);
    feed_words(v.n_words, v.use_fixed);
    @(negedge clk);
    check("after_load", dbg_state, v.exp_after);
    if (v.start_in_run) begin
      start = 1'b1; run_cycles = 2; dump_words = 1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    check("en_cycles", en_cnt, v.exp_en);
    check("en_rises", en_rises, (v.exp_en != 0));
    check("overflow", overflow, v.exp_ovf);
    check("dump_left", exp_m_q.size(), 0);
    check("imem_left", exp_w_q.size(), 0);
    check("done_flags", {busy, done, s_ready, cpu_enable, m_valid, wen_ext, ren_ext_2}, 7'b0100000);
    check("tieoff", {ren_ext, wen_ext_2, wdata_ext_2}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t;
    fixed_w[0] = 32'h2001_0005;
    fixed_w[1] = 32'h2002_0003;
    fixed_w[2] = 32'h0022_1820;
    for (int i = 0; i < 64; i++) dmem[i] = (i < 5) ? 32'(32'h11 * (i + 1)) : (32'hA500_0000 | 32'(i));

    //          words run dump fixed s_run ovf en  after
    vecs[0] = '{3,    10,  5,   1'b1, 1'b0, 1'b0, 10, RUN};
    vecs[1] = '{6,    0,   2,   1'b0, 1'b0, 1'b1, 0,  DUMP};
    vecs[2] = '{4,    1,   0,   1'b0, 1'b0, 1'b0, 1,  RUN};
    vecs[3] = '{2,    8,   3,   1'b0, 1'b1, 1'b0, 8,  RUN};
    vecs[4] = '{1,    0,   0,   1'b0, 1'b0, 1'b0, 0,  DONE};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();

    // First start coincides with reset release, then reset mid-LOAD.
    @(posedge clk); #1;
    arst_n = 1'b1; start = 1'b1; run_cycles = 0; dump_words = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("first_start", {dbg_state, s_ready, busy}, {LOAD, 2'b11});
    @(posedge clk); #1; arst_n = 1'b0;
    @(posedge clk); #1; arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    for (int i = 0; i < 5; i++) run_session(vecs[i]);

    // Reset for one cycle in the middle of a dump, then a full session.
    start_session(2, 5);
    feed_words(1, 1'b0);
    t = 0;
    while (m_xfer < 2 && t < 500) begin @(negedge clk); t++; end
    check("dump_two_seen", (m_xfer >= 2), 1);
    @(posedge clk); #1;
    arst_n = 1'b0;
    exp_m_q.delete();
    exp_w_q.delete();
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    run_session(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 512, instruction-memory depth in words.
REQ-002 Parameter CNT_W, default 32, width of run and dump counters.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 arst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that latches run_cycles and dump_words and begins a session.
REQ-006 run_cycles  in  CNT_W  number of cycles cpu_enable is held high.
REQ-007 dump_words  in  CNT_W  number of data-memory words streamed out after the run.
REQ-008 s_valid, s_ready, s_data[31:0], s_last  in/out/in/in  program word stream; a transfer occurs when s_valid && s_ready.
REQ-009 addr_ext[31:0], wen_ext, ren_ext, wdata_ext[31:0]  out  instruction-memory external port toward cpu.
REQ-010 addr_ext_2[31:0], wen_ext_2, ren_ext_2, wdata_ext_2[31:0]  out; rdata_ext_2[31:0]  in  data-memory external port.
REQ-011 cpu_enable  out  1  drives cpu enable.
REQ-012 m_valid, m_ready, m_data[31:0]  out/in/out  dump stream; a transfer occurs when m_valid && m_ready.
REQ-013 busy, done, overflow  out  1 each  status.

Function
REQ-014 FSM states IDLE, LOAD, RUN, DUMP, DONE; start is honoured only in IDLE or DONE and moves to LOAD, clearing done and overflow.
REQ-015 LOAD: s_ready=1; the k-th accepted word (k from 0) produces wen_ext=1, addr_ext=4*k, wdata_ext=s_data exactly one cycle after acceptance (registered outputs).
REQ-016 Words accepted with k >= IMEM_WORDS produce no write and set overflow (sticky); s_ready stays 1 until s_last is accepted.
REQ-017 Acceptance with s_last=1 writes that word (if k < IMEM_WORDS) and moves to RUN; the next state is entered the cycle after the final write.
REQ-018 ren_ext, wen_ext_2, wdata_ext_2 are constant 0; wen_ext is 0 outside the write cycle.
REQ-019 RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, then DUMP; run_cycles=0 goes directly to DUMP with no enable cycle.
REQ-020 DUMP: reads data memory at byte addresses 0,4,...,4*(dump_words-1) via ren_ext_2/addr_ext_2; sram read latency is 1 cycle.
REQ-021 DUMP uses a 2-entry output FIFO; a read is issued only when FIFO occupancy + reads in flight < 2; m_data follows address order with no loss or duplication under any m_ready pattern.
REQ-022 m_valid = FIFO not empty; m_data = FIFO head; m_data is stable while m_valid && !m_ready.
REQ-023 DUMP ends when all dump_words words are transferred; dump_words=0 goes directly to DONE.
REQ-024 DONE: done=1, all ports idle; holds until start.
REQ-025 busy=1 in LOAD, RUN, DUMP; else 0.
REQ-026 Counters are CNT_W bits, unsigned; no wrap occurs for run_cycles or dump_words up to 2^CNT_W-1.

Reset
REQ-027 arst_n low at a clock edge forces IDLE, empties FIFO, clears counters and overflow, and drives every output to 0 (s_ready, wen_ext, addr_ext, wdata_ext, ren_ext_2, addr_ext_2, cpu_enable, m_valid, m_data, busy, done, overflow), including mid-LOAD/RUN/DUMP.
REQ-028 The first start is honoured on the first edge with arst_n high.

Structure
REQ-029 State encoding enum and the address stride constant (4) reside in the shared cpu package.
REQ-030 The 2-entry output FIFO is one sub-module, fifo_2deep, parameterised by DATA_W.

Verification
REQ-031 Load 3 words (0x20010005, 0x20020003, 0x00221820, last on third) with s_valid gaps -> wen_ext pulses at addr 0,4,8 with those data; overflow=0.
REQ-032 IMEM_WORDS=4, stream 6 words -> 4 writes (addr 0..12), overflow=1, FSM reaches RUN after sixth word.
REQ-033 run_cycles=10 -> cpu_enable high exactly 10 cycles; run_cycles=0 -> never high, DUMP entered next cycle.
REQ-034 dump_words=5, data mem preloaded 0x11..0x55, m_ready toggled randomly 50% -> m_data sequence 0x11,0x22,0x33,0x44,0x55 exactly, then done=1.
REQ-035 arst_n low for one cycle during DUMP after 2 words -> all outputs 0 next cycle, FSM IDLE; new start completes a full session correctly.
REQ-036 start asserted during RUN -> ignored; run length and dump unchanged.
